// File: rtl/i2s_tx_ece10243upb.sv
// I2S transmitter: one-entry valid/ready holding buffer feeding a 2*SLOT_W-bit I2S frame.
// Optional UNDERRUN_CNT_EN adds a saturating underrun_count output.
module i2s_tx_ece10243upb #(
  parameter int DATA_W   = 24,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              i2s_bclk,
  output logic              i2s_lrck,
  output logic              i2s_sdata,
`ifdef UNDERRUN_CNT_EN
  output logic [15:0]       underrun_count,
`endif
  output logic              underrun
);

  localparam int FRAME = 2 * SLOT_W;
  localparam int B_W   = $clog2(FRAME);
  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic              bclk_q, bclk_d;
  logic [B_W-1:0]    b_q, b_d;
  logic              lrck_q, lrck_d;
  logic              sdata_q, sdata_d;
  logic              underrun_q, underrun_d;
  logic              full_q, full_d;
  logic [DATA_W-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic [DATA_W-1:0] frm_l_q, frm_l_d, frm_r_q, frm_r_d;

  logic              div_wrap, fall, frame_start, right_slot, data_bit;
  logic [B_W-1:0]    b_next, p, rel;
  logic [DATA_W-1:0] chan;

  always_comb begin
    div_wrap    = (div_cnt_q == DIV_W'(BCLK_DIV - 1));
    fall        = div_wrap & bclk_q;
    frame_start = fall & (b_q == B_W'(FRAME - 1));
    b_next      = (b_q == B_W'(FRAME - 1)) ? '0 : b_q + B_W'(1);
    right_slot  = (b_next >= B_W'(SLOT_W));
    p           = right_slot ? b_next - B_W'(SLOT_W) : b_next;
    rel         = B_W'(DATA_W) - p;
    chan        = right_slot ? frm_r_q : frm_l_q;
    // One-bit I2S delay: slot position p carries sample bit DATA_W-p.
    data_bit    = ((p != '0) && (p <= B_W'(DATA_W))) ? chan[rel[IDX_W-1:0]] : 1'b0;
  end

  always_comb begin
    div_cnt_d  = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
    bclk_d     = div_wrap ? ~bclk_q : bclk_q;
    b_d        = b_q;
    lrck_d     = lrck_q;
    sdata_d    = sdata_q;
    underrun_d = 1'b0;
    full_d     = full_q;
    buf_l_d    = buf_l_q;
    buf_r_d    = buf_r_q;
    frm_l_d    = frm_l_q;
    frm_r_d    = frm_r_q;

    if (fall) begin
      b_d     = b_next;
      lrck_d  = right_slot;
      sdata_d = data_bit;
    end

    if (frame_start) begin
      if (full_q) begin
        frm_l_d = buf_l_q;
        frm_r_d = buf_r_q;
        full_d  = 1'b0;
      end else begin
        underrun_d = 1'b1;
      end
    end

    // Gated on the pre-edge full flag, so an unload edge never also captures.
    if (in_valid && !full_q) begin
      buf_l_d = in_left;
      buf_r_d = in_right;
      full_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q  <= '0;
      bclk_q     <= 1'b0;
      b_q        <= B_W'(FRAME - 1);
      lrck_q     <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
      full_q     <= 1'b0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
      frm_l_q    <= '0;
      frm_r_q    <= '0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      bclk_q     <= bclk_d;
      b_q        <= b_d;
      lrck_q     <= lrck_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
      full_q     <= full_d;
      buf_l_q    <= buf_l_d;
      buf_r_q    <= buf_r_d;
      frm_l_q    <= frm_l_d;
      frm_r_q    <= frm_r_d;
    end
  end

`ifdef UNDERRUN_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (underrun_d && (cnt_q != '1)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign underrun_count = cnt_q;
`endif

  assign in_ready  = ~full_q;
  assign i2s_bclk  = bclk_q;
  assign i2s_lrck  = lrck_q;
  assign i2s_sdata = sdata_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_i2s_tx_ece10243upb.sv
// Scoreboard bench for i2s_tx_ece10243upb: frame-level reference model vs. captured I2S frames.
module tb_i2s_tx_ece10243upb;

  localparam int DATA_W   = 24;
  localparam int SLOT_W   = 32;
  localparam int BCLK_DIV = 2;
  localparam int FRAME_CLK = 2 * SLOT_W * 2 * BCLK_DIV;  // 256 clk per frame
  localparam int FIRST_FS  = 2 * BCLK_DIV;               // first fall / frame start edge

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] in_left, in_right;
  logic              in_valid;
  logic              in_ready, i2s_bclk, i2s_lrck, i2s_sdata, underrun;
`ifdef UNDERRUN_CNT_EN
  logic [15:0]       underrun_count;
`endif

  i2s_tx_ece10243upb #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .BCLK_DIV(BCLK_DIV)) dut (
    .clk(clk),
    .reset(reset),
    .in_left(in_left),
    .in_right(in_right),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .i2s_bclk(i2s_bclk),
    .i2s_lrck(i2s_lrck),
    .i2s_sdata(i2s_sdata),
`ifdef UNDERRUN_CNT_EN
    .underrun_count(underrun_count),
`endif
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
    logic              und;
  } frame_t;

  frame_t sb[$];

  // Reference model: frame starts every FRAME_CLK edges; one-entry buffer.
  int                mcyc;
  logic              mfull;
  logic [DATA_W-1:0] mbuf_l, mbuf_r, mfrm_l, mfrm_r;
  logic [15:0]       mucnt;

  always @(posedge clk) begin
    if (!reset) begin
      mcyc = 0; mfull = 1'b0; mucnt = '0;
      mbuf_l = '0; mbuf_r = '0; mfrm_l = '0; mfrm_r = '0;
      sb.delete();
    end else begin
      bit was_full;
      frame_t f;
      mcyc++;
      was_full = mfull;
      if (mcyc >= FIRST_FS && ((mcyc - FIRST_FS) % FRAME_CLK) == 0) begin
        f.und = !was_full;
        if (was_full) begin
          mfrm_l = mbuf_l; mfrm_r = mbuf_r; mfull = 1'b0;
        end else if (mucnt != 16'hFFFF) begin
          mucnt++;
        end
        f.l = mfrm_l; f.r = mfrm_r;
        sb.push_back(f);
      end
      if (!was_full && in_valid) begin
        mbuf_l = in_left; mbuf_r = in_right; mfull = 1'b1;
      end
    end
  end

  // Monitor: capture sdata/lrck on each BCLK rise, 64 rises per frame.
  int          mb, nrise, ucnt;
  bit          active, prevb;
  logic [63:0] sd, lr;

  always @(negedge clk) begin
    if (!reset) begin
      mb = 2 * SLOT_W - 1; prevb = 1'b0; active = 1'b0; nrise = 0; ucnt = 0;
    end else begin
      check("in_ready", in_ready, !mfull);
`ifdef UNDERRUN_CNT_EN
      check("underrun_count", underrun_count, mucnt);
`endif
      if (prevb && !i2s_bclk) begin
        mb = (mb + 1) % (2 * SLOT_W);
        if (mb == 0) begin
          active = 1'b1; nrise = 0; ucnt = 0; sd = '0; lr = '0;
        end
      end
      if (active && underrun) ucnt++;
      if (!prevb && i2s_bclk && active) begin
        sd = {sd[62:0], i2s_sdata};
        lr = {lr[62:0], i2s_lrck};
        nrise++;
        if (nrise == 2 * SLOT_W) begin
          active = 1'b0;
          if (sb.size() == 0) begin
            check("frame_expected", 64'd0, 64'd1);
          end else begin
            frame_t e;
            e = sb.pop_front();
            check("frame_sdata", sd, {1'b0, e.l, 7'b0, 1'b0, e.r, 7'b0});
            check("frame_lrck", lr, {32'h0, 32'hFFFF_FFFF});
            check("frame_underrun", 64'(ucnt), 64'(e.und));
          end
        end
      end
      prevb = i2s_bclk;
    end
  end

  task automatic send(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    bit ok = 1'b0;
    in_left = l; in_right = r; in_valid = 1'b1;
    for (int n = 0; n < 2 * FRAME_CLK; n++) begin
      if (in_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("send_accept_timeout", ok, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_pos(input int pos, input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 2 * FRAME_CLK; n++) begin
      @(negedge clk);
      if (mcyc >= FIRST_FS && ((mcyc - FIRST_FS) % FRAME_CLK) == pos) begin ok = 1'b1; break; end
    end
    check(name, ok, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bclk"}, i2s_bclk, 1'b0);
    check({tag, "_lrck"}, i2s_lrck, 1'b0);
    check({tag, "_sdata"}, i2s_sdata, 1'b0);
    check({tag, "_underrun"}, underrun, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
`ifdef UNDERRUN_CNT_EN
    check({tag, "_ucount"}, underrun_count, 16'd0);
`endif
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_left = '0; in_right = '0;
    repeat (5) @(posedge clk);
    #1;
    check_reset_outputs("rst");

    @(negedge clk); #2 reset = 1'b1;
    @(negedge clk); check("bclk_e1", i2s_bclk, 1'b0);
    @(negedge clk); check("bclk_e2_rise", i2s_bclk, 1'b1);
    @(negedge clk); check("bclk_e3", i2s_bclk, 1'b1);
    @(negedge clk);
    check("bclk_e4_fall", i2s_bclk, 1'b0);
    check("lrck_e4", i2s_lrck, 1'b0);
    check("sdata_e4", i2s_sdata, 1'b0);
    check("underrun_e4", underrun, 1'b1);

    send(24'hA5C3F0, 24'h5A0F3C);

    // Back-pressure: back-to-back random pairs, each waits for a frame start.
    for (int i = 0; i < 4; i++) send(DATA_W'($urandom), DATA_W'($urandom));

    // Underrun: buffer drains, frames repeat the last pair.
    repeat (4 * FRAME_CLK) @(negedge clk);

    // Mid-frame reset with a pair still buffered.
    send(DATA_W'($urandom), DATA_W'($urandom));
    wait_pos(0, "wait_frame_start");
    send(DATA_W'($urandom), DATA_W'($urandom));
    wait_pos(4 * 10, "wait_b10");
    #1 reset = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    repeat (FIRST_FS + 2 * FRAME_CLK + 4) @(negedge clk);
`ifdef UNDERRUN_CNT_EN
    check("ucount_3_empty", underrun_count, 16'd3);
`endif
    repeat (FRAME_CLK) @(negedge clk);
    check("sb_drained", sb.size() <= 1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(20000 * 10);
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2s_tx_ece10243upb.md
Name: i2s_tx_ece10243upb

Overview:
- Downstream stage of the FIR filter: serializes the filtered 24-bit audio samples into a standard I2S stream (BCLK, LRCK, SDATA) for the board audio codec DAC.
- Runs on the single system clock; BCLK is derived by an internal divider.
- A one-entry holding buffer with valid/ready decouples the filter sample rate from the I2S frame rate.
- Underruns repeat the last sample and raise a flag.

Parameters:
- DATA_W, 24, sample width per channel; must satisfy DATA_W <= SLOT_W-1.
- SLOT_W, 32, BCLK periods per channel slot; frame = 2*SLOT_W BCLK periods.
- BCLK_DIV, 4, clk cycles per BCLK half-period; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_left  input  DATA_W  left-channel sample (two's complement).
- in_right  input  DATA_W  right-channel sample; top level ties both channels to the filter output for mono.
- in_valid  input  1  sample pair valid.
- in_ready  output  1  holding buffer empty; transfer occurs when in_valid & in_ready on a clk edge.
- i2s_bclk  output  1  bit clock, 50% duty, period 2*BCLK_DIV clk cycles.
- i2s_lrck  output  1  word select; 0 = left slot, 1 = right slot.
- i2s_sdata  output  1  serial data, MSB first, changes only on BCLK falling events.
- underrun  output  1  one-clk pulse when a frame starts with the holding buffer empty.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - i2s_bclk=0, i2s_lrck=0, i2s_sdata=0, underrun=0, in_ready=1.
  - Holding buffer empty; frame shift registers cleared to 0.
  - div_cnt=0; bit counter b=2*SLOT_W-1.
- Divider: div_cnt counts 0..BCLK_DIV-1. On the clk edge where div_cnt==BCLK_DIV-1, div_cnt wraps to 0 and i2s_bclk toggles.
  - A toggle 0->1 is a rise event.
  - A toggle 1->0 is a fall event.
  - The first rise occurs BCLK_DIV clk cycles after reset release.
- Frame sequencing on each fall event:
  - b increments modulo 2*SLOT_W; the first fall after reset wraps b to 0 (frame start).
  - i2s_lrck = (b >= SLOT_W), registered in the same cycle as the BCLK fall.
  - i2s_sdata, with p = b mod SLOT_W (standard I2S one-bit delay):
    - 1 <= p <= DATA_W: bit DATA_W-p of the current channel's frame register.
    - Otherwise: 0.
- Frame start (b wraps to 0):
  - Buffer full: frame registers load the buffered left/right pair, buffer marked empty.
  - Buffer empty: frame registers keep the previous pair (zeros if none since reset) and underrun pulses high for exactly that one clk.
- Buffer handshake:
  - in_ready = buffer empty.
  - On in_valid & in_ready the buffer captures in_left/in_right and in_ready falls the next cycle.
  - A new sample is never accepted while full; in_valid held high simply waits.
  - Simultaneous frame-start unload and input valid in the same clk: unload wins; in_ready was 0 that cycle, so no capture. in_ready=1 next cycle and capture occurs then.
- Latency: a sample accepted at least one clk before a frame start appears starting at BCLK fall b=1 of that frame (left MSB); right MSB at b=SLOT_W+1.
- Rise events change nothing except i2s_bclk; data is stable across every rise (codec samples on rise).
- Reset mid-frame: all outputs return to reset values immediately. The partial frame is dropped and a buffered sample is discarded.

Optional Feature:
- Macro UNDERRUN_CNT_EN.
- Defined: adds output underrun_count [15:0].
  - Saturating count of underrun pulses; saturates at 16'hFFFF.
  - Cleared by reset.
  - Counts the first-frame underrun after reset.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan (DATA_W=24, SLOT_W=32, BCLK_DIV=2, so frame = 256 clk):
- Reset: hold reset=0 for 5 clk -> all outputs 0, in_ready=1. Release -> first i2s_bclk rise at clk 2, first fall at clk 4 with lrck=0, sdata=0, and one underrun pulse (empty buffer).
- Single frame: present left=24'hA5C3F0, right=24'h5A0F3C with in_valid before first frame start -> accepted in 1 clk. Sampling sdata on bclk rises, b=1..24 yields A5C3F0 MSB first, b=25..31 zeros, lrck=1 from b=32, b=33..56 yields 5A0F3C. No underrun.
- Back-pressure: hold in_valid=1 with a new pair while the buffer is full -> in_ready=0 until the next frame start. Capture occurs on the clk after unload; each pair is transmitted exactly once, in order.
- Underrun: after one valid pair, drive in_valid=0 -> next frame repeats the same pair bit-exactly and underrun pulses once per frame start (width 1 clk).
- Reset mid-frame: assert reset at b=10 of a frame -> outputs 0 asynchronously (same cycle). After release the frame restarts at b=0 with zeros plus an underrun; the previously buffered pair is not transmitted.
- UNDERRUN_CNT_EN defined: 3 consecutive empty frames after reset -> underrun_count=3. Reset clears it to 0.
